// File: rtl/merge_frame_arbiter_pkg.sv
// Shared definitions for the merge-path arbiters: FSM state encoding and
// merge-group sizing.
package merge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_BLOCK = 2'd2
  } state_e;

  localparam int THW_DEFAULT = 6;
  localparam int GRP_FRAMES  = 2 ** THW_DEFAULT;

  // Frames per merge group for a given group-size exponent.
  function automatic int grp_frames(input int thw);
    return 1 << thw;
  endfunction

endpackage

// File: rtl/merge_frame_arbiter_if.sv
// Channel-side and pipeline-side streams of the frame arbiter. The arbiter
// takes the master view; the environment takes the slave view.
interface merge_frame_arbiter_if #(
  parameter int NCH  = 4,
  parameter int DW   = 32,
  parameter int SW   = 8,
  parameter int SHW  = 32,
  parameter int THHW = 32
);
  logic [NCH-1:0]      s_valid;
  logic [NCH-1:0]      s_ready;
  logic [NCH-1:0]      s_last;
  logic [NCH*DW-1:0]   s_data;
  logic [NCH*SHW-1:0]  s_sh;
  logic [NCH*THHW-1:0] s_thh;
  logic                m_ready;
  logic                m_valid;
  logic                m_last;
  logic [DW-1:0]       m_data;
  logic [SHW-1:0]      m_sh;
  logic [THHW-1:0]     m_thh;
  logic [SW-1:0]       m_ch;

  modport master (
    input  s_valid, s_last, s_data, s_sh, s_thh, m_ready,
    output s_ready, m_valid, m_last, m_data, m_sh, m_thh, m_ch
  );

  modport slave (
    output s_valid, s_last, s_data, s_sh, s_thh, m_ready,
    input  s_ready, m_valid, m_last, m_data, m_sh, m_thh, m_ch
  );
endinterface

// File: rtl/merge_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo NCH (NCH need not be a power of two).
module rr_pick #(
  parameter int NCH = 4,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [IW-1:0]  idx,
  output logic           any_req
);

  int k;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    idx     = '0;
    any_req = 1'b0;
    k       = 0;
    for (int i = 0; i < NCH; i++) begin
      k = int'(ptr) + i;
      if (k >= NCH) k = k - NCH;
      if (!any_req && req[k]) begin
        any_req = 1'b1;
        idx     = IW'(k);
      end
    end
  end

endmodule

// File: rtl/merge_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding merge_pipeline: holds a grant for a
// whole frame, counts frames per merge group, stalls while the pipeline swaps banks.
module merge_frame_arbiter
  import merge_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int DW   = 32,
  parameter int SW   = 8,
  parameter int SHW  = 32,
  parameter int THW  = 6,
  parameter int THHW = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  merge_frame_arbiter_if.master bus,
  input  logic [THW:0]         pipe_th,
  output logic [THW-1:0]       grp_cnt,
  output logic                 grp_done
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [THW:0] GRP_TH = (THW + 1)'(grp_frames(THW));

  state_e          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   win;
  logic            any_req;
  logic            xfer;
  logic            accept_last;
  logic            sel_valid;
  logic            sel_last;
  logic [DW-1:0]   sel_data;
  logic [SHW-1:0]  sel_sh;
  logic [THHW-1:0] sel_thh;

  rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .req     (bus.s_valid),
    .ptr     (rr_ptr),
    .idx     (win),
    .any_req (any_req)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_sh    = '0;
    sel_thh   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant == IW'(k)) begin
        sel_valid = bus.s_valid[k];
        sel_last  = bus.s_last[k];
        sel_data  = bus.s_data[k*DW +: DW];
        sel_sh    = bus.s_sh[k*SHW +: SHW];
        sel_thh   = bus.s_thh[k*THHW +: THHW];
      end
    end
  end

  // Zero-latency pass-through while a frame is granted; payload is zero when idle.
  assign xfer         = (state == ST_XFER);
  assign bus.m_valid  = xfer & sel_valid;
  assign bus.m_last   = bus.m_valid & sel_last;
  assign bus.m_data   = bus.m_valid ? sel_data : '0;
  assign bus.m_sh     = bus.m_valid ? sel_sh   : '0;
  assign bus.m_thh    = bus.m_valid ? sel_thh  : '0;
  assign accept_last  = bus.m_valid & bus.m_ready & bus.m_last;

  always_comb begin
    bus.s_ready = '0;
    if (xfer) bus.s_ready[grant] = bus.m_ready;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      bus.m_ch <= '0;
      grp_cnt  <= '0;
      grp_done <= 1'b0;
    end else begin
      grp_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pipe_th == GRP_TH) begin
            state <= ST_BLOCK;
          end else if (any_req) begin
            grant    <= win;
            bus.m_ch <= SW'(win);
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept_last) begin
            rr_ptr   <= (grant == IW'(NCH - 1)) ? '0 : grant + IW'(1);
            grp_cnt  <= grp_cnt + THW'(1);
            grp_done <= &grp_cnt;
            state    <= ST_IDLE;
          end
        end
        ST_BLOCK: begin
          if (pipe_th < GRP_TH) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_frame_arbiter.sv
// Self-checking bench for merge_frame_arbiter: directed scenarios plus randomized
// frames scored against a round-robin frame-order model.
module tb_merge_frame_arbiter;
  import merge_pkg::*;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int SW   = 8;
  localparam int SHW  = 8;
  localparam int THW  = 2;
  localparam int THHW = 8;
  localparam int GF   = 1 << THW;

  typedef struct {
    logic [DW-1:0]   data;
    logic [SHW-1:0]  sh;
    logic [THHW-1:0] thh;
    logic            last;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [THW:0]   pipe_th;
  logic [THW-1:0] grp_cnt;
  logic           grp_done;

  merge_frame_arbiter_if #(.NCH(NCH), .DW(DW), .SW(SW), .SHW(SHW), .THHW(THHW)) bus ();

  merge_frame_arbiter #(
    .NCH(NCH), .DW(DW), .SW(SW), .SHW(SHW), .THW(THW), .THHW(THHW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .pipe_th  (pipe_th),
    .grp_cnt  (grp_cnt),
    .grp_done (grp_done)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  beat_t       srcq[NCH][$];
  logic [63:0] exp_q[$];
  bit          mid[NCH];
  int          drop_cnt[NCH];
  int          cyc = 0;
  int          beats = 0;
  int          done_pulses = 0;
  int          acc_cyc[$];
  int          exp_grp = 0;
  bit          exp_done = 1'b0;
  bit          tog = 1'b1;
  int          fid = 0;
  logic [NCH-1:0] smp_ready;
  logic           smp_valid;
  logic [SW-1:0]  smp_ch;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pack(input int ch, input beat_t b);
    return {23'd0, SW'(ch), b.data, b.sh, b.thh, b.last};
  endfunction

  task automatic load_frame(input int ch, input int len, input bit push_exp);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = DW'((ch << 12) | ((fid & 255) << 4) | (i & 15));
      b.sh   = SHW'($urandom);
      b.thh  = THHW'($urandom);
      b.last = (i == len - 1);
      srcq[ch].push_back(b);
      if (push_exp) exp_q.push_back(pack(ch, b));
    end
    fid++;
  endtask

  task automatic drive();
    logic [NCH-1:0]      v, l;
    logic [NCH*DW-1:0]   d;
    logic [NCH*SHW-1:0]  s;
    logic [NCH*THHW-1:0] t;
    v = '0; l = '0; d = '0; s = '0; t = '0;
    for (int k = 0; k < NCH; k++) begin
      if (srcq[k].size() > 0 && drop_cnt[k] == 0) begin
        v[k] = 1'b1;
        l[k] = srcq[k][0].last;
        d[k*DW +: DW]     = srcq[k][0].data;
        s[k*SHW +: SHW]   = srcq[k][0].sh;
        t[k*THHW +: THHW] = srcq[k][0].thh;
      end
    end
    bus.s_valid = v;
    bus.s_last  = l;
    bus.s_data  = d;
    bus.s_sh    = s;
    bus.s_thh   = t;
  endtask

  // One clock: drive, sample at negedge, then retire accepted beats after posedge.
  // mode 0: m_ready=1, 1: alternating, 2: random with mid-frame valid gaps.
  task automatic step(input int mode);
    logic [NCH-1:0] acc, midm;
    bit             lastacc;
    beat_t          b;
    case (mode)
      1:       begin bus.m_ready = tog; tog = !tog; end
      2:       bus.m_ready = ($urandom % 4) != 0;
      default: bus.m_ready = 1'b1;
    endcase
    drive();
    @(negedge clk);
    smp_ready = bus.s_ready;
    smp_valid = bus.m_valid;
    smp_ch    = bus.m_ch;
    chk("grp", {grp_cnt, grp_done}, {exp_grp[THW-1:0], exp_done});
    midm = '0;
    for (int k = 0; k < NCH; k++) midm[k] = mid[k];
    if (midm != '0) chk("hold_grant", bus.s_ready & ~midm, '0);
    if (!bus.m_valid) chk("idle_payload", {bus.m_data, bus.m_sh, bus.m_thh, bus.m_last}, '0);
    acc     = bus.s_valid & bus.s_ready;
    lastacc = 1'b0;
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) chk("extra_beat", exp_q.size(), 1);
      else chk("beat", {23'd0, bus.m_ch, bus.m_data, bus.m_sh, bus.m_thh, bus.m_last},
               exp_q.pop_front());
      lastacc = bus.m_last;
      beats++;
      acc_cyc.push_back(cyc);
    end
    if (grp_done) done_pulses++;
    @(posedge clk);
    #1;
    cyc++;
    if (lastacc) begin
      exp_done = (exp_grp == GF - 1);
      exp_grp  = (exp_grp + 1) % GF;
    end else begin
      exp_done = 1'b0;
    end
    for (int k = 0; k < NCH; k++) if (drop_cnt[k] > 0) drop_cnt[k]--;
    for (int k = 0; k < NCH; k++) begin
      if (acc[k]) begin
        b      = srcq[k].pop_front();
        mid[k] = !b.last;
        if (mode == 2 && mid[k] && ($urandom % 3) == 0) drop_cnt[k] = $urandom_range(1, 3);
      end
    end
  endtask

  task automatic run_until(input int n, input int mode, input int budget, input string tag);
    int target, c;
    target = beats + n;
    c = 0;
    while (beats < target && c < budget) begin
      step(mode);
      c++;
    end
    chk(tag, beats, target);
  endtask

  task automatic clear_sources();
    for (int k = 0; k < NCH; k++) begin
      srcq[k].delete();
      mid[k]      = 1'b0;
      drop_cnt[k] = 0;
    end
    exp_q.delete();
    exp_grp  = 0;
    exp_done = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.m_ready = 1'b0;
    pipe_th     = '0;
    clear_sources();
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int nfr[NCH];
    int rd[NCH];
    int total, mptr, kk, left;

    reset = 1'b1;
    pipe_th = '0;
    bus.m_ready = 1'b0;
    clear_sources();
    drive();
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, '0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_ch", bus.m_ch, 0);
    chk("rst_payload", {bus.m_data, bus.m_sh, bus.m_thh}, '0);
    chk("rst_grp", {grp_cnt, grp_done}, '0);
    @(posedge clk);
    #1;

    // All four channels valid, 2-beat frames: grants 0,1,2,3,0 with 3-cycle frame pitch
    load_frame(0, 2, 1);
    load_frame(1, 2, 1);
    load_frame(2, 2, 1);
    load_frame(3, 2, 1);
    load_frame(0, 2, 1);
    acc_cyc.delete();
    run_until(10, 0, 60, "rr_beats");
    chk("rr_intra", acc_cyc[1] - acc_cyc[0], 1);
    for (int f = 0; f < 4; f++) chk("rr_pitch", acc_cyc[2*f+2] - acc_cyc[2*f], 3);

    // ch2 valid gap mid-frame while ch0/ch1 wait: grant must stay on ch2
    load_frame(2, 4, 1);
    run_until(1, 0, 10, "gap_first");
    load_frame(0, 2, 1);
    load_frame(1, 1, 1);
    drop_cnt[2] = 3;
    repeat (3) begin
      step(0);
      chk("gap_ch0_ready", smp_ready[0], 0);
      chk("gap_ch1_ready", smp_ready[1], 0);
      chk("gap_m_valid", smp_valid, 0);
      chk("gap_m_ch", smp_ch, 2);
    end
    run_until(6, 0, 40, "gap_rest");

    // Alternating m_ready during a 4-beat frame
    load_frame(0, 4, 1);
    tog = 1'b1;
    run_until(4, 1, 20, "bp_beats");
    repeat (3) step(0);
    chk("bp_count", exp_q.size(), 0);

    // Lone ch3 is regranted every frame; ch0 wins once it raises valid
    load_frame(3, 2, 1);
    load_frame(3, 2, 1);
    run_until(4, 0, 30, "solo_ch3");
    load_frame(0, 2, 1);
    load_frame(3, 2, 1);
    run_until(4, 0, 30, "ch0_wins");

    // Reset in the middle of a ch1 frame (3 of 6 beats delivered)
    load_frame(1, 6, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back(pack(1, srcq[1][i]));
    run_until(3, 0, 20, "rm_beats");
    chk("rm_grp_before", grp_cnt, 1);
    reset = 1'b1;
    bus.m_ready = 1'b0;
    drive();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rm_s_ready", bus.s_ready, '0);
    chk("rm_m_valid", bus.m_valid, 0);
    chk("rm_grp", {grp_cnt, grp_done}, '0);
    chk("rm_m_ch", bus.m_ch, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_sources();
    drive();

    // Group of four single-beat frames; order 0..3 also shows rr_ptr restarted at 0
    done_pulses = 0;
    for (int k = 0; k < NCH; k++) load_frame(k, 1, 1);
    run_until(4, 0, 30, "grp_frames");
    repeat (2) step(0);
    chk("grp_done_once", done_pulses, 1);
    chk("grp_wrap", grp_cnt, 0);

    // Bank switch: pipe_th at group size holds everything off, then frame issue resumes
    pipe_th = (THW + 1)'(GF);
    load_frame(1, 2, 1);
    repeat (5) begin
      step(0);
      chk("blk_s_ready", smp_ready, '0);
      chk("blk_m_valid", smp_valid, 0);
    end
    pipe_th = '0;
    run_until(2, 0, 10, "blk_resume");

    // Randomized frames against a round-robin frame-order model
    do_reset();
    mptr = 0;
    for (int r = 0; r < 6; r++) begin
      total = 0;
      left  = 0;
      for (int k = 0; k < NCH; k++) begin
        nfr[k] = $urandom_range(0, 3);
        rd[k]  = 0;
        left  += nfr[k];
        for (int f = 0; f < nfr[k]; f++) load_frame(k, $urandom_range(1, 4), 0);
      end
      while (left > 0) begin
        kk = -1;
        for (int i = 0; i < NCH && kk < 0; i++)
          if (nfr[(mptr + i) % NCH] > 0) kk = (mptr + i) % NCH;
        do begin
          exp_q.push_back(pack(kk, srcq[kk][rd[kk]]));
          rd[kk]++;
          total++;
        end while (!srcq[kk][rd[kk]-1].last);
        nfr[kk]--;
        left--;
        mptr = (kk + 1) % NCH;
      end
      run_until(total, 2, 400, "rnd_beats");
    end
    repeat (3) step(0);
    chk("exp_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
